nn_argmax_stage: RTL and testbench
==================================

// Module: nn_argmax_stage
// PURPOSE
//   Downstream consumer of a neural-network layer output stream. Collects one M-element
//   vector of signed T-bit activations over a valid/ready handshake and tracks the running
//   maximum. It then emits the winning index and its value as a single classification result,
//   also over valid/ready. It sits after the final layer_*_* stage of the network.
// PARAMETERS
//   T   16  element width in bits (signed two's complement)
//   M   4   elements per input vector; M >= 1
//   IW  $clog2(M>1?M:2)  index width; localparam, not overridable
// PORTS
//   clk      in   1    clock; all state changes on posedge
//   reset    in   1    synchronous, active-high
//   s_valid  in   1    upstream element valid
//   s_ready  out  1    block accepts an element this cycle
//   data_in  in   T    signed element, consumed when s_valid & s_ready
//   m_valid  out  1    result valid
//   m_ready  in   1    downstream accepts result
//   idx_out  out  IW   index (0..M-1) of the maximum element
//   max_out  out  T    signed value of the maximum element
// BEHAVIOUR
//   - Clock and reset: clock clk; reset reset, synchronous, active-high.
//   - Reset values: state=COLLECT, elem_cnt=0, m_valid=0, idx_out=0, max_out=0.
//     s_ready=0 while reset is high, else follows state.
//   - FSM states:
//     - COLLECT: s_ready=1, m_valid=0.
//     - OUTPUT: s_ready=0, m_valid=1, idx_out/max_out held stable.
//   - Accept: an element is accepted when s_valid & s_ready.
//     - Element number elem_cnt==0: best_val<=data_in, best_idx<=0.
//     - Element k>0: signed compare; if data_in > best_val, then best_val<=data_in and best_idx<=k.
//   - COLLECT->OUTPUT: on acceptance of element M-1. elem_cnt wraps to 0.
//     idx_out/max_out register the final winner, including when element M-1 itself wins.
//     m_valid=1 on the next cycle.
//   - OUTPUT->COLLECT: on m_valid & m_ready. s_ready=1 on the next cycle.
//     No element is accepted in the handoff cycle (one-cycle bubble per vector).
//   - Latency: last element accepted at cycle n -> m_valid high at n+1.
//     Throughput: M+1 cycles per vector at best.
//   - s_valid gaps in COLLECT: state is held, no partial timeout.
//     m_ready low in OUTPUT: hold indefinitely, outputs unchanged.
//   - M==1: every accepted element yields idx_out=0, max_out=data_in.
//   - Reset mid-vector or mid-OUTPUT: the partial vector or pending result is discarded.
//     The first element after reset is element 0.
//   - Compare is full-width signed, with no saturation or rounding; max_out is the exact input value.
//   - s_valid high while s_ready low: ignored; data is not consumed.
// CONFIGURATION
//   NN_ARGMAX_TIE_LAST_EN
//     - Defined: the compare is >=, so on a tie the LAST equal element wins.
//     - Undefined (default): the compare is strict >, so on a tie the FIRST equal element wins.
//     - Nothing else changes.
// TESTING
//   (T=16, M=4 unless noted)
//   1. Stream 5,-3,20,7 back-to-back, m_ready=1
//      -> m_valid 1 cycle after 4th beat; idx_out=2, max_out=20; s_ready back 1 cycle later.
//   2. Stream -7,-2,-9,-2
//      -> default idx_out=1, max_out=-2; with NN_ARGMAX_TIE_LAST_EN idx_out=3, max_out=-2.
//   3. Vector 0,0,0,100, then hold m_ready=0 for 6 cycles
//      -> idx_out=3, max_out=100 stable, s_ready=0 throughout.
//      Next vector 9,1,1,1 after m_ready -> idx_out=0, max_out=9.
//   4. Send 50,60, assert reset for 1 cycle, then send 1,2,3,4 with random s_valid gaps
//      -> single result idx_out=3, max_out=4; nothing emitted for 50,60.
//   5. Extremes -32768,32767,-1,32767
//      -> idx_out=1, max_out=32767 (default); idx_out=3 with the tie-last macro.
//   6. M=1 build: stream -5 then 8 with m_ready=1
//      -> two results: (idx 0, -5) then (idx 0, 8).

Source files
------------

// File: rtl/nn_argmax_stage.sv
// Argmax stage: collects M signed elements over valid/ready, emits (index, value) of the maximum.
// Optional macro NN_ARGMAX_TIE_LAST_EN: ties resolve to the last equal element instead of the first.
module nn_argmax_stage #(
    parameter  int T  = 16,
    parameter  int M  = 4,
    localparam int IW = $clog2(M > 1 ? M : 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [T-1:0]  data_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [IW-1:0] idx_out,
    output logic [T-1:0]  max_out
);

    typedef enum logic {COLLECT, OUTPUT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] elem_cnt_q, elem_cnt_d;
    logic [T-1:0]  best_val_q, best_val_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [IW-1:0] idx_out_q, idx_out_d;
    logic [T-1:0]  max_out_q, max_out_d;

    logic          accept;
    logic          last_elem;
    logic          better;
    logic          take;
    logic [T-1:0]  win_val;
    logic [IW-1:0] win_idx;

    assign s_ready = ~reset & (state_q == COLLECT);
    assign m_valid = (state_q == OUTPUT);
    assign idx_out = idx_out_q;
    assign max_out = max_out_q;

    // The winner including the current element, so element M-1 can win directly into the outputs.
    always_comb begin
        accept    = s_valid & s_ready;
        last_elem = (elem_cnt_q == IW'(M - 1));
`ifdef NN_ARGMAX_TIE_LAST_EN
        better    = ($signed(data_in) >= $signed(best_val_q));
`else
        better    = ($signed(data_in) > $signed(best_val_q));
`endif
        take      = (elem_cnt_q == '0) | better;
        win_val   = take ? data_in : best_val_q;
        win_idx   = take ? elem_cnt_q : best_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        idx_out_d  = idx_out_q;
        max_out_d  = max_out_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    best_val_d = win_val;
                    best_idx_d = win_idx;
                    if (last_elem) begin
                        elem_cnt_d = '0;
                        idx_out_d  = win_idx;
                        max_out_d  = win_val;
                        state_d    = OUTPUT;
                    end else begin
                        elem_cnt_d = elem_cnt_q + IW'(1);
                    end
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            elem_cnt_q <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            idx_out_q  <= '0;
            max_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            idx_out_q  <= idx_out_d;
            max_out_q  <= max_out_d;
        end
    end

endmodule

// File: tb/tb_nn_argmax_stage.sv
// Bench for nn_argmax_stage: an M=4 and an M=1 instance share the stimulus and are compared
// every cycle against a queue-based argmax model, plus directed literal checks.
module tb_nn_argmax_stage;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic [15:0] data_in;
    logic        m_ready;

    logic        s_ready0, m_valid0;
    logic [1:0]  idx_out0;
    logic [15:0] max_out0;
    logic        s_ready1, m_valid1;
    logic [0:0]  idx_out1;
    logic [15:0] max_out1;

    int total = 0;
    int bad   = 0;

    nn_argmax_stage #(.T(16), .M(4)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0), .data_in(data_in),
        .m_valid(m_valid0), .m_ready(m_ready), .idx_out(idx_out0), .max_out(max_out0)
    );

    nn_argmax_stage #(.T(16), .M(1)) dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .data_in(data_in),
        .m_valid(m_valid1), .m_ready(m_ready), .idx_out(idx_out1), .max_out(max_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Reference model: accepted elements go into a queue; a full queue is reduced to its argmax.
    int mq0[$];
    int mq1[$];
    bit pend[2];
    int eidx[2];
    int emax[2];

    function automatic void argmax(input int q[$], output int bi, output int bv);
        bi = 0;
        bv = q[0];
        for (int i = 1; i < q.size(); i++) begin
`ifdef NN_ARGMAX_TIE_LAST_EN
            if (q[i] >= bv) begin
`else
            if (q[i] > bv) begin
`endif
                bv = q[i];
                bi = i;
            end
        end
    endfunction

    always @(posedge clk) begin
        int bi, bv;
        if (reset) begin
            mq0.delete();
            mq1.delete();
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            if (pend[0]) begin
                if (m_ready) pend[0] = 1'b0;
            end else if (s_valid) begin
                mq0.push_back(int'($signed(data_in)));
                if (mq0.size() == 4) begin
                    argmax(mq0, bi, bv);
                    eidx[0] = bi;
                    emax[0] = bv;
                    pend[0] = 1'b1;
                    mq0.delete();
                end
            end
            if (pend[1]) begin
                if (m_ready) pend[1] = 1'b0;
            end else if (s_valid) begin
                mq1.push_back(int'($signed(data_in)));
                argmax(mq1, bi, bv);
                eidx[1] = bi;
                emax[1] = bv;
                pend[1] = 1'b1;
                mq1.delete();
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("m4_m_valid", int'(m_valid0), int'(pend[0]));
        checkOutput("m4_s_ready", int'(s_ready0), int'(!reset && !pend[0]));
        if (pend[0]) begin
            checkOutput("m4_idx_out", int'(idx_out0), eidx[0]);
            checkOutput("m4_max_out", int'($signed(max_out0)), emax[0]);
        end
        checkOutput("m1_m_valid", int'(m_valid1), int'(pend[1]));
        checkOutput("m1_s_ready", int'(s_ready1), int'(!reset && !pend[1]));
        if (pend[1]) begin
            checkOutput("m1_idx_out", int'(idx_out1), eidx[1]);
            checkOutput("m1_max_out", int'($signed(max_out1)), emax[1]);
        end
    end

    // Results leaving the M=1 instance while capture is enabled.
    bit cap1 = 1'b0;
    int cap_idx[$];
    int cap_max[$];
    always @(negedge clk) begin
        if (cap1 && m_valid1 && m_ready) begin
            cap_idx.push_back(int'(idx_out1));
            cap_max.push_back(int'($signed(max_out1)));
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) stepCycle();
    endtask

    // Present one element and hold it until the M=4 instance accepts it.
    task automatic applyStimulus(input int v);
        bit rdy;
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        data_in = 16'(v);
        for (int c = 0; c < 50 && !done; c++) begin
            rdy = s_ready0;
            stepCycle();
            done = rdy;
        end
        if (!done) checkOutput("beat_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic sendVector(input int a, input int b, input int c, input int d);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
        applyStimulus(d);
    endtask

    task automatic pulseReset();
        reset   = 1'b1;
        s_valid = 1'b0;
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        data_in = '0;
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        stepCycle();
        checkOutput("rst_m_valid", int'(m_valid0), 0);
        checkOutput("rst_s_ready", int'(s_ready0), 0);
        checkOutput("rst_idx_out", int'(idx_out0), 0);
        checkOutput("rst_max_out", int'(max_out0), 0);
        reset = 1'b0;
        idle(1);
        checkOutput("rst_s_ready_after", int'(s_ready0), 1);

        // Test 1: basic vector, latency and bubble.
        sendVector(5, -3, 20, 7);
        checkOutput("t1_m_valid", int'(m_valid0), 1);
        checkOutput("t1_s_ready", int'(s_ready0), 0);
        checkOutput("t1_idx", int'(idx_out0), 2);
        checkOutput("t1_max", int'($signed(max_out0)), 20);
        idle(1);
        checkOutput("t1_s_ready_back", int'(s_ready0), 1);

        // Test 2: tie handling.
        sendVector(-7, -2, -9, -2);
`ifdef NN_ARGMAX_TIE_LAST_EN
        checkOutput("t2_idx", int'(idx_out0), 3);
`else
        checkOutput("t2_idx", int'(idx_out0), 1);
`endif
        checkOutput("t2_max", int'($signed(max_out0)), -2);
        idle(1);

        // Test 3: backpressure on the result, last element wins.
        m_ready = 1'b0;
        sendVector(0, 0, 0, 100);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t3_hold_valid", int'(m_valid0), 1);
            checkOutput("t3_hold_idx", int'(idx_out0), 3);
            checkOutput("t3_hold_max", int'($signed(max_out0)), 100);
            checkOutput("t3_hold_s_ready", int'(s_ready0), 0);
            idle(1);
        end
        m_ready = 1'b1;
        sendVector(9, 1, 1, 1);
        checkOutput("t3_idx2", int'(idx_out0), 0);
        checkOutput("t3_max2", int'($signed(max_out0)), 9);
        idle(1);

        // Test 4: reset discards a partial vector.
        applyStimulus(50);
        applyStimulus(60);
        pulseReset();
        for (int v = 1; v <= 4; v++) begin
            idle($urandom_range(0, 2));
            if (v == 4) checkOutput("t4_no_early", int'(m_valid0), 0);
            applyStimulus(v);
        end
        checkOutput("t4_valid", int'(m_valid0), 1);
        checkOutput("t4_idx", int'(idx_out0), 3);
        checkOutput("t4_max", int'($signed(max_out0)), 4);
        idle(1);

        // Test 5: full-scale extremes.
        sendVector(-32768, 32767, -1, 32767);
`ifdef NN_ARGMAX_TIE_LAST_EN
        checkOutput("t5_idx", int'(idx_out0), 3);
`else
        checkOutput("t5_idx", int'(idx_out0), 1);
`endif
        checkOutput("t5_max", int'($signed(max_out0)), 32767);
        idle(1);

        // Random traffic, backpressure and occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) data_in = 16'($urandom);
            else data_in = 16'(int'($urandom_range(0, 6)) - 3);
            m_ready = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 199) == 0);
            stepCycle();
        end
        reset   = 1'b0;
        m_ready = 1'b1;

        // Test 6: M=1 instance yields one result per element.
        pulseReset();
        idle(2);
        cap1 = 1'b1;
        applyStimulus(-5);
        idle(1);
        applyStimulus(8);
        idle(3);
        cap1 = 1'b0;
        checkOutput("t6_count", cap_idx.size(), 2);
        if (cap_idx.size() == 2) begin
            checkOutput("t6_idx0", cap_idx[0], 0);
            checkOutput("t6_max0", cap_max[0], -5);
            checkOutput("t6_idx1", cap_idx[1], 0);
            checkOutput("t6_max1", cap_max[1], 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
